// File: rtl/fir_seq_pkg.sv
// Shared types for the FIR sample sequencer: FSM state encoding and FIR operation codes.
package fir_seq_pkg;

  typedef enum logic [2:0] {
    FILL     = 3'd0,
    LOAD     = 3'd1,
    COMP     = 3'd2,
    READ_SET = 3'd3,
    READ_OUT = 3'd4
  } state_e;

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_COMP = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

endpackage

// File: rtl/fir_sample_sequencer_if.sv
// Sample stream, FIR engine and result stream signals of the sequencer.
// master = sequencer side, slave = environment (source, FIR engine, sink).
interface fir_sample_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic [1:0]        fir_operation;
  logic [ADDR_W-1:0] fir_addr;
  logic [DATA_W-1:0] fir_x;
  logic [DATA_W-1:0] fir_y;
  logic              fir_done;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    input  s_valid, s_data, fir_y, fir_done, m_ready,
    output s_ready, fir_operation, fir_addr, fir_x, m_valid, m_data, m_last
  );

  modport slave (
    output s_valid, s_data, fir_y, fir_done, m_ready,
    input  s_ready, fir_operation, fir_addr, fir_x, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fir_seq_out_reg.sv
// Result holding register: loads a result with its last flag, holds it until the
// valid/ready handshake completes.
module fir_seq_out_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
      m_last  <= load_last;
    end else if (m_valid && ready) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/fir_sample_sequencer.sv
// Buffers one frame of samples, runs the FIR load/compute/read protocol and streams results out.
// Optional compute watchdog: define FIR_SEQ_TIMEOUT_EN.
module fir_sample_sequencer
  import fir_seq_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int SIGNAL_COUNT = 10,
  parameter int ADDR_W       = 32,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  fir_sample_sequencer_if.master bus,
  output logic                   busy,
  output logic                   err
);

  localparam int CNT_W = $clog2(SIGNAL_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIGNAL_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SIGNAL_COUNT);

  if (SIGNAL_COUNT < 2 || TIMEOUT_CYC < 1) begin : g_cfg_chk
    $error("fir_sample_sequencer: SIGNAL_COUNT must be >= 2 and TIMEOUT_CYC >= 1");
  end

  state_e            state;
  logic [CNT_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  cnt;       // load address in LOAD, result index k in READ_*
  logic [CNT_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] sbuf [SIGNAL_COUNT];
  logic              s_ready_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] x_q;
  logic              s_fire;
  logic              m_fire;
  logic              tmo_hit;

  assign s_fire            = bus.s_valid && s_ready_q;
  assign m_fire            = bus.m_valid && bus.m_ready;
  assign cnt_nxt           = cnt + 1'b1;
  assign bus.s_ready       = s_ready_q;
  assign bus.fir_operation = op_q;
  assign bus.fir_addr      = ADDR_W'(cnt);
  assign bus.fir_x         = x_q;
  assign busy              = (state != FILL);

  always_ff @(posedge clk) begin
    if (s_fire) sbuf[wr_ptr] <= bus.s_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      wr_ptr    <= '0;
      cnt       <= '0;
      s_ready_q <= 1'b0;
      op_q      <= OP_IDLE;
      x_q       <= '0;
    end else begin
      case (state)
        FILL: begin
          // a full buffer waits for the FIR to drop done from the previous frame
          if (wr_ptr == CNT_FULL) begin
            if (!bus.fir_done) begin
              state <= LOAD;
              op_q  <= OP_LOAD;
              cnt   <= '0;
              x_q   <= sbuf[0];
            end
          end else if (s_fire) begin
            wr_ptr    <= wr_ptr + 1'b1;
            s_ready_q <= (wr_ptr != CNT_LAST);
          end else begin
            s_ready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (cnt == CNT_FULL) begin
            state <= COMP;
            op_q  <= OP_COMP;
            cnt   <= '0;
          end else begin
            cnt <= cnt_nxt;
            x_q <= (cnt_nxt < CNT_FULL) ? sbuf[cnt_nxt] : '0;
          end
        end
        COMP: begin
          if (bus.fir_done) begin
            state <= READ_SET;
            op_q  <= OP_READ;
            cnt   <= '0;
          end else if (tmo_hit) begin
            state     <= FILL;
            op_q      <= OP_IDLE;
            wr_ptr    <= '0;
            s_ready_q <= 1'b1;
          end
        end
        READ_SET: state <= READ_OUT;
        READ_OUT: begin
          if (m_fire) begin
            if (cnt == CNT_LAST) begin
              state     <= FILL;
              op_q      <= OP_IDLE;
              cnt       <= '0;
              wr_ptr    <= '0;
              s_ready_q <= 1'b1;
            end else begin
              cnt   <= cnt_nxt;
              state <= READ_SET;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // fir_y for the address presented this cycle is captured at the end of READ_SET
  fir_seq_out_reg #(.DATA_W(DATA_W)) u_out (
    .clk       (clk),
    .reset     (reset),
    .load      (state == READ_SET),
    .load_data (bus.fir_y),
    .load_last (cnt == CNT_LAST),
    .ready     (bus.m_ready),
    .m_valid   (bus.m_valid),
    .m_data    (bus.m_data),
    .m_last    (bus.m_last)
  );

`ifdef FIR_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  assign tmo_hit = (state == COMP) && !bus.fir_done && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign err     = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= (state == COMP) ? tmo_cnt + 1'b1 : '0;
      if (tmo_hit) err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Directed bench for fir_sample_sequencer with a FIR stub returning y[a] = x[a] + 100.
module tb_fir_sample_sequencer;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SC = 10;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic err;
  int   ncmp = 0;
  int   nerr = 0;

  fir_sample_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  fir_sample_sequencer #(
    .DATA_W(DW), .SIGNAL_COUNT(SC), .ADDR_W(AW), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  // FIR stub: captures samples during load, answers reads combinationally
  logic [DW-1:0] fir_mem [SC];
  always @(posedge clk)
    if (bus.fir_operation == 2'b01 && bus.fir_addr < SC) fir_mem[bus.fir_addr[3:0]] <= bus.fir_x;
  assign bus.fir_y = (bus.fir_addr < SC) ? fir_mem[bus.fir_addr[3:0]] + 32'd100 : '0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"}, bus.s_ready, 0);
    chk({tag, "_op"}, bus.fir_operation, 0);
    chk({tag, "_addr"}, bus.fir_addr, 0);
    chk({tag, "_x"}, bus.fir_x, 0);
    chk({tag, "_m_valid"}, bus.m_valid, 0);
    chk({tag, "_m_data"}, bus.m_data, 0);
    chk({tag, "_m_last"}, bus.m_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic fill_frame(input int base);
    for (int i = 1; i <= SC; i++) begin
      for (int w = 0; w < 20 && !bus.s_ready; w++) tick();
      chk("s_ready_fill", bus.s_ready, 1);
      bus.s_valid = 1'b1;
      bus.s_data  = base + i;
      tick();
    end
    bus.s_valid = 1'b0;
    chk("s_ready_full", bus.s_ready, 0);
  endtask

  task automatic load_frame(input int base);
    for (int j = 0; j <= SC; j++) begin
      tick();
      chk("op_load", bus.fir_operation, 1);
      chk("addr_load", bus.fir_addr, j);
      chk("x_load", bus.fir_x, (j < SC) ? base + j + 1 : 0);
    end
    tick();
    chk("op_comp", bus.fir_operation, 2);
    chk("busy_comp", busy, 1);
  endtask

  task automatic comp_done(input int delay);
    for (int d = 1; d < delay; d++) tick();
    bus.fir_done = 1'b1;
    tick();
    bus.fir_done = 1'b0;
    chk("op_read", bus.fir_operation, 3);
    chk("addr_read0", bus.fir_addr, 0);
  endtask

  task automatic read_all(input int base);
    int w;
    bus.m_ready = 1'b1;
    for (int k = 0; k < SC; k++) begin
      w = 0;
      while (!bus.m_valid && w < 8) begin tick(); w++; end
      chk("m_valid_rd", bus.m_valid, 1);
      chk("m_data_rd", bus.m_data, base + k + 101);
      chk("m_last_rd", bus.m_last, k == SC - 1);
      tick();
    end
    chk("s_ready_after_rd", bus.s_ready, 1);
    chk("op_after_rd", bus.fir_operation, 0);
    chk("busy_after_rd", busy, 0);
    chk("m_valid_after_rd", bus.m_valid, 0);
  endtask

  initial begin
    int            idx;
    int            w;
    logic          stalled;
    logic [DW-1:0] held;

    // reset held with s_valid high
    reset = 1'b0;
    bus.s_valid = 1'b1; bus.s_data = 32'd55; bus.m_ready = 1'b0; bus.fir_done = 1'b0;
    tick(); tick();
    chk_all_zero("rst");
    reset = 1'b1;
    bus.s_valid = 1'b0;
    tick();
    chk("s_ready_release", bus.s_ready, 1);

    // frame 1..10, done pulsed 5 cycles into COMP, m_ready high
    fill_frame(0);
    load_frame(0);
    comp_done(5);
    read_all(0);

    // frame 11..20, m_ready toggling, s_valid held during READ
    fill_frame(10);
    load_frame(10);
    comp_done(1);
    bus.s_valid = 1'b1; bus.s_data = 32'd99; bus.m_ready = 1'b1;
    idx = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 100 && busy; c++) begin
      if (stalled) begin
        chk("m_valid_hold", bus.m_valid, 1);
        chk("m_data_hold", bus.m_data, held);
      end
      chk("s_ready_busy", bus.s_ready, 0);
      if (bus.m_valid && bus.m_ready) begin
        chk("m_data_tog", bus.m_data, 111 + idx);
        chk("m_last_tog", bus.m_last, idx == SC - 1);
        idx++;
      end
      stalled = bus.m_valid && !bus.m_ready;
      held = bus.m_data;
      tick();
      bus.m_ready = ~bus.m_ready;
    end
    bus.s_valid = 1'b0;
    chk("n_results_tog", idx, SC);
    chk("s_ready_tog_end", bus.s_ready, 1);

    // fir_done held high when buffer fills: stay in FILL until it drops
    bus.fir_done = 1'b1;
    fill_frame(20);
    for (int h = 0; h < 3; h++) begin
      tick();
      chk("op_hold_fill", bus.fir_operation, 0);
      chk("busy_hold_fill", busy, 0);
    end
    bus.fir_done = 1'b0;
    load_frame(20);
    comp_done(2);
    read_all(20);

    // reset while holding result 3
    fill_frame(30);
    load_frame(30);
    comp_done(2);
    bus.m_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      w = 0;
      while (!bus.m_valid && w < 8) begin tick(); w++; end
      chk("m_data_pre", bus.m_data, 131 + k);
      tick();
    end
    bus.m_ready = 1'b0;
    w = 0;
    while (!bus.m_valid && w < 8) begin tick(); w++; end
    tick(); tick();
    chk("m_valid_stall3", bus.m_valid, 1);
    chk("m_data_stall3", bus.m_data, 133);
    reset = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick();
    reset = 1'b1;
    tick();
    chk("s_ready_rerelease", bus.s_ready, 1);
    fill_frame(40);
    load_frame(40);
    comp_done(1);
    read_all(40);
    chk("err_default", err, 0);

`ifdef FIR_SEQ_TIMEOUT_EN
    // no fir_done: watchdog trips after TMO compute cycles
    fill_frame(50);
    load_frame(50);
    for (int t = 1; t < TMO; t++) tick();
    chk("err_before_tmo", err, 0);
    chk("op_before_tmo", bus.fir_operation, 2);
    tick();
    chk("err_tmo", err, 1);
    chk("op_tmo", bus.fir_operation, 0);
    chk("m_valid_tmo", bus.m_valid, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
